// File: rtl/mux_channel_scanner_if.sv
// Frame delivery bus: assembled scan frame offered downstream on valid/ready.
interface mux_channel_scanner_if;
    localparam int unsigned CHANNELS = 32;

    logic [CHANNELS-1:0] frame;
    logic                frame_valid;
    logic                frame_ready;

    modport master (output frame, output frame_valid, input frame_ready);
    modport slave  (input frame, input frame_valid, output frame_ready);
endinterface

// File: rtl/mux_channel_scanner.sv
// Channel scanner in front of a 32:1 mux: drives the select, samples one enabled
// channel per clock into a frame and hands the frame off on valid/ready.
// Optional build macro SCAN_AUTO_RESTART_EN: a frame transfer immediately starts
// the next scan with the retained mask instead of returning to IDLE.
module mux_channel_scanner (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            mask,
    input  logic                   mux_bit,
    output logic [4:0]             s,
    output logic                   busy,
    output logic                   done,
    mux_channel_scanner_if.master  frame_bus
);
    localparam int unsigned CHANNELS = 32;
    localparam int unsigned SEL_W    = $clog2(CHANNELS);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t              state;
    state_t              state_d;
    logic [CHANNELS-1:0] mask_q;
    logic [CHANNELS-1:0] frame_q;
    logic [SEL_W-1:0]    sel_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;

    logic [CHANNELS-1:0] above_sel;
    logic                has_higher;
    logic                xfer;
    logic [SEL_W-1:0]    first_sel;
    logic [SEL_W-1:0]    next_sel;

    // Lowest set index of a channel vector (0 when empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        lowest_set = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = SEL_W'(i);
        end
    endfunction

    // Enabled channels strictly above the current select; empty once 31 is reached.
    assign above_sel  = mask_q & ~((CHANNELS'(2) << sel_q) - CHANNELS'(1));
    assign has_higher = |above_sel;
    assign next_sel   = lowest_set(above_sel);
    assign first_sel  = lowest_set(mask);
    assign xfer       = (state == HOLD) && frame_bus.frame_ready;

`ifdef SCAN_AUTO_RESTART_EN
    logic [SEL_W-1:0] restart_sel;
    assign restart_sel = lowest_set(mask_q);
`endif

    // State register and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) state_d = (|mask) ? SCAN : HOLD;
            end
            SCAN: begin
                if (!has_higher) state_d = HOLD;
            end
            HOLD: begin
`ifdef SCAN_AUTO_RESTART_EN
                if (xfer) state_d = (|mask_q) ? SCAN : HOLD;
`else
                if (xfer) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags follow the state being entered; done marks a transfer edge.
    always_comb begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
        done_d  = xfer;
    end

    // Select, sample capture and mask retention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            frame_q <= '0;
            mask_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q  <= mask;
                        frame_q <= '0;
                        if (|mask) sel_q <= first_sel;
                    end
                end
                SCAN: begin
                    frame_q[sel_q] <= mux_bit;
                    if (has_higher) sel_q <= next_sel;
                end
                HOLD: begin
`ifdef SCAN_AUTO_RESTART_EN
                    if (xfer) begin
                        frame_q <= '0;
                        if (|mask_q) sel_q <= restart_sel;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign s                     = sel_q;
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign frame_bus.frame       = frame_q;
    assign frame_bus.frame_valid = valid_q;
endmodule

// File: tb/tb_mux_channel_scanner.sv
// Randomized scoreboard bench for mux_channel_scanner (default build).
module tb_mux_channel_scanner;
    typedef struct {
        logic [31:0] frame;
        int          valid_cyc;
        logic [4:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] mask;
    logic [31:0] ip;
    logic        mux_bit;
    logic [4:0]  s;
    logic        busy;
    logic        done;

    mux_channel_scanner_if fbus ();

    mux_channel_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mask      (mask),
        .mux_bit   (mux_bit),
        .s         (s),
        .busy      (busy),
        .done      (done),
        .frame_bus (fbus.master)
    );

    // Combinational mux model behind the select.
    assign mux_bit = ip[s];

    always #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;
    exp_t fq[$];
    int   s_q[$];
    logic [4:0] model_s = 5'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: samples once per cycle between edges and checks against the scoreboard.
    logic valid_prev = 1'b0;
    logic xfer_pending = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   es;
        #1;
        if (rst) begin
            valid_prev   = 1'b0;
            xfer_pending = 1'b0;
        end else begin
            chk("done", 32'(done), 32'(xfer_pending));
            xfer_pending = 1'b0;
            if (busy && !fbus.frame_valid) begin
                if (s_q.size() == 0) begin
                    chk("scan_unexpected", 32'(1), 32'(0));
                end else begin
                    es = s_q.pop_front();
                    chk("scan_sel", 32'(s), 32'(es));
                end
            end
            if (fbus.frame_valid) begin
                if (fq.size() == 0) begin
                    chk("valid_unexpected", 32'(1), 32'(0));
                end else begin
                    e = fq[0];
                    chk("frame", fbus.frame, e.frame);
                    chk("hold_sel", 32'(s), 32'(e.sel));
                    if (!valid_prev) chk("latency", 32'(cyc), 32'(e.valid_cyc));
                    if (fbus.frame_ready) begin
                        void'(fq.pop_front());
                        xfer_pending = 1'b1;
                    end
                end
            end
            valid_prev = fbus.frame_valid && !fbus.frame_ready;
        end
    end

    // Reference expectations: enabled channels in ascending order, frame = ip & mask.
    task automatic push_expect(input logic [31:0] m, input logic [31:0] v, input int accept_cyc);
        exp_t e;
        int   n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                s_q.push_back(i);
                n++;
                model_s = 5'(i);
            end
        end
        e.frame     = m & v;
        e.valid_cyc = accept_cyc + n;
        e.sel       = model_s;
        fq.push_back(e);
    endtask

    task automatic run_scan(input logic [31:0] m, input logic [31:0] v, input int hold,
                            input bit early_ready, input bit junk);
        int to = 0;
        while (busy || fbus.frame_valid) begin
            @(negedge clk);
            to++;
            if (to > 200) begin
                chk("idle_timeout", 32'(1), 32'(0));
                return;
            end
        end
        ip               = v;
        mask             = m;
        start            = 1'b1;
        fbus.frame_ready = early_ready;
        push_expect(m, v, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        mask  = $urandom;
        to = 0;
        while (!fbus.frame_valid) begin
            if (junk) begin
                start = 1'($urandom_range(0, 1));
                mask  = $urandom;
            end
            @(negedge clk);
            to++;
            if (to > 40) begin
                start = 1'b0;
                chk("valid_timeout", 32'(1), 32'(0));
                return;
            end
        end
        start = 1'b0;
        if (!early_ready) begin
            repeat (hold) begin
                if (junk) begin
                    start = 1'($urandom_range(0, 1));
                    mask  = $urandom;
                end
                @(negedge clk);
            end
            start            = 1'b0;
            fbus.frame_ready = 1'b1;
        end
        @(negedge clk);
        fbus.frame_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s"}, 32'(s), 32'(0));
        chk({tag, "_frame"}, fbus.frame, 32'(0));
        chk({tag, "_valid"}, 32'(fbus.frame_valid), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int to;
        logic [31:0] m;
        rst              = 1'b1;
        start            = 1'b0;
        mask             = '0;
        ip               = '0;
        fbus.frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");

        // Full scan with downstream always ready.
        run_scan(32'hFFFF_FFFF, 32'hA5C3_0F96, 0, 1'b1, 1'b0);
        // Sparse mask: channels 0, 4, 31 only.
        run_scan(32'h8000_0011, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        // Backpressure with ignored start pulses.
        run_scan(32'h0F0F_3C01, $urandom, 10, 1'b0, 1'b1);
        // Empty mask: straight to HOLD, select untouched.
        run_scan(32'h0000_0000, $urandom, 2, 1'b0, 1'b0);

        // Reset in the middle of a full scan.
        @(negedge clk);
        ip    = $urandom;
        mask  = 32'hFFFF_FFFF;
        start = 1'b1;
        push_expect(32'hFFFF_FFFF, ip, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        to = 0;
        while (s != 5'd12 && to < 40) begin
            @(negedge clk);
            to++;
        end
        chk("reach_sel12", 32'(s), 32'(12));
        rst = 1'b1;
        #1;
        chk_zero("mid_reset");
        s_q.delete();
        fq.delete();
        model_s = 5'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_scan(32'hFFFF_FFFF, $urandom, 1, 1'b0, 1'b0);

        // Randomized scans.
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0:       m = 32'h0;
                1:       m = 32'hFFFF_FFFF;
                2:       m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            run_scan(m, $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(fq.size() + s_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
